// File: rtl/mmss_stopwatch.sv
// rtl/mmss_stopwatch.sv - MM:SS stopwatch: prescaler, run/pause/clear FSM, saturating digit chain.
// Optional lap/hold snapshot display is built when STOPWATCH_LAP_EN is defined.
module mmss_stopwatch #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       clear,
`ifdef STOPWATCH_LAP_EN
  input  logic       lap,
  output logic       held,
`endif
  output logic [3:0] sec_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [2:0] min_tens,
  output logic       running,
  output logic       wrap
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic          start_prev;
  logic [3:0]    cnt_so;
  logic [2:0]    cnt_st;
  logic [3:0]    cnt_mo;
  logic [2:0]    cnt_mt;

  logic          start_edge;
  logic          tick;
  logic [4:0]    s0, s1, s2, s3;

  // {carry, digit}: any value+ci at or beyond the limit restarts at 0 and carries
  function automatic logic [4:0] sat_inc(input logic [3:0] v, input logic ci, input logic [4:0] lim);
    logic [4:0] sum;
    sum = {1'b0, v} + {4'b0000, ci};
    if (sum >= lim) return 5'b10000;
    else            return {1'b0, sum[3:0]};
  endfunction

  always_comb begin
    start_edge = start_stop & ~start_prev;
    tick       = (state == RUN) && (presc == PRESC_LAST);
    s0         = sat_inc(cnt_so, tick, 5'd10);
    s1         = sat_inc({1'b0, cnt_st}, s0[4], 5'd6);
    s2         = sat_inc(cnt_mo, s1[4], 5'd10);
    s3         = sat_inc({1'b0, cnt_mt}, s2[4], 5'd6);
  end

`ifdef STOPWATCH_LAP_EN
  logic       lap_prev;
  logic       lap_edge;
  logic [3:0] snap_so;
  logic [2:0] snap_st;
  logic [3:0] snap_mo;
  logic [2:0] snap_mt;

  assign lap_edge = lap & ~lap_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      lap_prev <= 1'b0;
      held     <= 1'b0;
      snap_so  <= 4'd0;
      snap_st  <= 3'd0;
      snap_mo  <= 4'd0;
      snap_mt  <= 3'd0;
    end else begin
      lap_prev <= lap;
      if (clear) begin
        held <= 1'b0;
      end else if (state == RUN && lap_edge) begin
        held <= ~held;
        // capture the pre-count value when entering hold
        if (!held) begin
          snap_so <= cnt_so;
          snap_st <= cnt_st;
          snap_mo <= cnt_mo;
          snap_mt <= cnt_mt;
        end
      end
    end
  end

  assign sec_ones = held ? snap_so : cnt_so;
  assign sec_tens = held ? snap_st : cnt_st;
  assign min_ones = held ? snap_mo : cnt_mo;
  assign min_tens = held ? snap_mt : cnt_mt;
`else
  assign sec_ones = cnt_so;
  assign sec_tens = cnt_st;
  assign min_ones = cnt_mo;
  assign min_tens = cnt_mt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      presc      <= '0;
      start_prev <= 1'b0;
      cnt_so     <= 4'd0;
      cnt_st     <= 3'd0;
      cnt_mo     <= 4'd0;
      cnt_mt     <= 3'd0;
      running    <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      start_prev <= start_stop;
      wrap       <= 1'b0;
      if (clear) begin
        state   <= IDLE;
        presc   <= '0;
        cnt_so  <= 4'd0;
        cnt_st  <= 3'd0;
        cnt_mo  <= 4'd0;
        cnt_mt  <= 3'd0;
        running <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_edge) begin
              state   <= RUN;
              presc   <= '0;
              running <= 1'b1;
            end
          end
          RUN: begin
            if (tick) begin
              presc  <= '0;
              cnt_so <= s0[3:0];
              cnt_st <= s1[2:0];
              cnt_mo <= s2[3:0];
              cnt_mt <= s3[2:0];
              wrap   <= s3[4];
            end else begin
              presc <= presc + 1'b1;
            end
            if (start_edge) begin
              state   <= PAUSED;
              running <= 1'b0;
            end
          end
          PAUSED: begin
            if (start_edge) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          default: begin
            state   <= IDLE;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/mmss_stopwatch.md
# mmss_stopwatch

Four-digit minutes:seconds stopwatch counter for the BASYS3 lab design. It contains a prescaler that produces one count per TICK_DIV clock cycles and a run/pause/clear state machine. It also holds the digit registers; each digit advances through a saturating modulo-L incrementor chain. The four digit outputs feed the seven-segment display driver directly.

## Interface
- TICK_DIV, 100_000_000: clock cycles per count (1 s at 100 MHz); must be ≥ 2; prescaler width $clog2(TICK_DIV).
- clk  input  1  system clock; everything is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start_stop  input  1  run/pause request; acted on at its rising edge.
- clear  input  1  synchronous clear request; level-sensitive.
- lap  input  1  lap request; acted on at its rising edge. Present only with STOPWATCH_LAP_EN.
- sec_ones  output  4  seconds units digit, 0..9.
- sec_tens  output  3  seconds tens digit, 0..5.
- min_ones  output  4  minutes units digit, 0..9.
- min_tens  output  3  minutes tens digit, 0..5.
- running  output  1  high while in RUNNING.
- wrap  output  1  one-cycle pulse when the count rolls over from 59:59 to 00:00.
- held  output  1  high while the lap snapshot is displayed. Present only with STOPWATCH_LAP_EN.

## Operation
- States:
  - IDLE: digits are 0 and the prescaler is 0.
  - RUNNING.
  - PAUSED: digits and the prescaler are frozen.
- Edge detect: start_prev holds start_stop from the previous cycle and resets to 0. A start_stop rising edge (start_stop & ~start_prev) causes:
  - IDLE→RUNNING;
  - RUNNING→PAUSED;
  - PAUSED→RUNNING.
- A start_stop level held high causes exactly one transition.
- clear=1 in any state:
  - next state is IDLE;
  - digits, prescaler and held all go to 0;
  - any start_stop edge in the same cycle is ignored (clear wins).
- Prescaler in RUNNING:
  - if presc == TICK_DIV-1, then presc←0 and a count is issued;
  - otherwise presc←presc+1.
- Leaving RUNNING for PAUSED keeps the partial prescaler value. The next resume continues from it.
- Count chain, one saturating incrementor per digit, carry-in/carry-out chained:
  - sec_ones (L=10) → sec_tens (L=6) → min_ones (L=10) → min_tens (L=6).
  - Each stage: if value+ci ≥ L, the digit becomes 0 and co=1; otherwise digit = value+ci and co=0.
- Out-of-range digits (unreachable after reset) are still handled by the saturating stages: the digit becomes 0 and carries.
- wrap = 1 for exactly the cycle after the edge at which the chain goes from 59:59 to 00:00, i.e. when min_tens co=1.

## Timing
- Reset values:
  - state IDLE;
  - all digits 0;
  - presc 0;
  - running 0, wrap 0, held 0;
  - start_prev 0, lap_prev 0.
- reset has priority over clear and start_stop.
- The edge that registers a start_stop rising edge from IDLE enters RUNNING with presc=0. running goes high after that edge.
- The first increment happens on the TICK_DIV-th edge after entering RUNNING.
- A pause edge that coincides with presc == TICK_DIV-1 still increments on that edge, because the state was RUNNING during that cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Digits change only on count edges, on clear, and on reset.

## Configuration
- STOPWATCH_LAP_EN defined:
  - lap and held ports exist.
  - A lap rising edge while RUNNING toggles held. When held rises, the current digits are copied into snapshot registers.
  - While held=1, the digit outputs show the snapshot and the internal count keeps advancing.
  - held is cleared by clear, by reset, or by a lap edge.
  - A lap edge in IDLE or PAUSED is ignored.
- STOPWATCH_LAP_EN undefined:
  - no lap or held ports and no snapshot registers;
  - the digit outputs always show the live count.

## Test plan
- Reset and start, TICK_DIV=4: reset, then a start_stop pulse → running=1 one cycle later; sec_ones=1 after 4 edges, 2 after 8 edges; all digits 0 before the start.
- Carry chain: run from 00:09 → 00:10 on the next count. From 09:59 → 10:00, with all three lower digits changing on the same edge.
- Wrap: run to 59:59, then one count → 00:00, wrap high for exactly one cycle, running still 1.
- Pause and resume: pause with presc=2, hold for 20 cycles → digits and presc unchanged; resume → next increment after 2 edges. Hold start_stop high for 10 cycles → exactly one transition.
- Clear priority: clear and start_stop together in RUNNING at 03:27 → IDLE, 00:00, running=0. Clear asserted at the same time as reset → reset values.
- With STOPWATCH_LAP_EN: lap at 00:05 while running → outputs stay at 00:05 and held=1 while the internal count reaches 00:08. A second lap edge → outputs show 00:08 and held=0. A lap edge while PAUSED → no change.
